// File: rtl/mfp_eic_pkg.sv
// Shared constants and types for the microAptiv EIC-mode interrupt controller.
package mfp_eic_pkg;

  localparam int unsigned EIC_REG_EICR   = 0;
  localparam int unsigned EIC_REG_EIMSK  = 1;
  localparam int unsigned EIC_REG_EIFR   = 2;
  localparam int unsigned EIC_REG_EISMSK = 3;
  localparam int unsigned EIC_REG_EIRQ   = 4;

  localparam logic [16:0] EIC_OFFSET_BASE = 17'h200;
  localparam logic [16:0] EIC_OFFSET_STEP = 17'h20;

  typedef struct packed {
    logic [17:0] reserved;
    logic [7:0]  ripl;
    logic [5:0]  vector;
  } eic_eirq_t;

  function automatic logic [16:0] eic_offset(input logic [5:0] vec);
    return EIC_OFFSET_BASE + 17'(vec) * EIC_OFFSET_STEP;
  endfunction

endpackage

// File: rtl/mfp_eic_priority_enc.sv
// Combinational highest-set-bit encoder: returns whether any request is set and its top index.
module mfp_eic_priority_enc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [5:0]       index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (req[i]) begin
        valid = 1'b1;
        index = 6'(i);
      end
    end
  end

endmodule

// File: rtl/mfp_eic_handler.sv
// EIC-mode interrupt controller: latches, masks and prioritises requests for the core.
// Define MFP_EIC_INPUT_SYNC_EN to add a 2-flop synchroniser on every EIC_input bit.
module mfp_eic_handler
  import mfp_eic_pkg::*;
#(
  parameter int unsigned EIC_CHANNELS = 32,
  parameter int unsigned ADDR_WIDTH   = 3
) (
  input  logic                    SI_ClkIn,
  input  logic                    SI_Reset,
  input  logic [EIC_CHANNELS-1:0] EIC_input,
  input  logic                    SI_IAck,
  input  logic [5:0]              SI_IPL,
  input  logic [ADDR_WIDTH-1:0]   reg_addr,
  input  logic [31:0]             reg_wdata,
  input  logic                    reg_we,
  input  logic                    reg_re,
  output logic [31:0]             reg_rdata,
  output logic [7:0]              EIC_Interrupt,
  output logic [5:0]              EIC_Vector,
  output logic [16:0]             EIC_Offset,
  output logic [3:0]              EIC_ShadowSet
);

  localparam int unsigned CH = EIC_CHANNELS;

  logic [CH-1:0] in_s, prev_q, pend_q, pend_d, pending, rise, clr, ack_mask, active;
  logic [CH-1:0] eimsk_q, eismsk_q;
  logic          eicr_q;
  logic [7:0]    ripl_q;
  logic [5:0]    vec_q;
  logic [16:0]   off_q;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   addr_idx;
  logic          wr_eicr, wr_eimsk, wr_eifr, wr_eismsk;
  logic          ack_valid, cand_valid, present;
  logic [5:0]    cand_idx;
  logic [7:0]    cand_ripl;
  eic_eirq_t     eirq;

`ifdef MFP_EIC_INPUT_SYNC_EN
  logic [CH-1:0] sync1_q, sync2_q;

  always_ff @(posedge SI_ClkIn) begin
    if (SI_Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= EIC_input;
      sync2_q <= sync1_q;
    end
  end

  assign in_s = sync2_q;
`else
  assign in_s = EIC_input;
`endif

  assign addr_idx  = 32'(reg_addr);
  assign wr_eicr   = reg_we && (addr_idx == EIC_REG_EICR);
  assign wr_eimsk  = reg_we && (addr_idx == EIC_REG_EIMSK);
  assign wr_eifr   = reg_we && (addr_idx == EIC_REG_EIFR);
  assign wr_eismsk = reg_we && (addr_idx == EIC_REG_EISMSK);

  assign ack_valid = SI_IAck && (ripl_q != 8'd0);

  always_comb begin
    ack_mask = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      ack_mask[i] = ack_valid && (vec_q == 6'(i));
    end
  end

  // Edge flags live only for edge-sensed channels; a new rising edge beats any clear.
  assign rise    = in_s & ~prev_q;
  assign clr     = ((wr_eifr ? reg_wdata[CH-1:0] : '0) | ack_mask) & eismsk_q;
  assign pend_d  = (rise | (pend_q & ~clr)) & eismsk_q;
  assign pending = (pend_q & eismsk_q) | (in_s & ~eismsk_q);

  // The acknowledged channel is dropped from this arbitration so the core never sees it twice.
  assign active = eicr_q ? (pending & eimsk_q & ~(ack_mask & eismsk_q)) : '0;

  mfp_eic_priority_enc #(
    .WIDTH (CH)
  ) u_prio (
    .req   (active),
    .valid (cand_valid),
    .index (cand_idx)
  );

  assign cand_ripl = 8'(cand_idx) + 8'd1;
  assign present   = cand_valid && (cand_ripl > {2'b00, SI_IPL});

  always_comb begin
    eirq        = '0;
    eirq.ripl   = ripl_q;
    eirq.vector = vec_q;
    rdata_d     = '0;
    case (addr_idx)
      EIC_REG_EICR:   rdata_d[0]    = eicr_q;
      EIC_REG_EIMSK:  rdata_d[CH-1:0] = eimsk_q;
      EIC_REG_EIFR:   rdata_d[CH-1:0] = pending;
      EIC_REG_EISMSK: rdata_d[CH-1:0] = eismsk_q;
      EIC_REG_EIRQ:   rdata_d       = eirq;
      default:        rdata_d       = '0;
    endcase
  end

  always_ff @(posedge SI_ClkIn) begin
    if (SI_Reset) begin
      prev_q   <= '0;
      pend_q   <= '0;
      eicr_q   <= 1'b0;
      eimsk_q  <= '0;
      eismsk_q <= '0;
      ripl_q   <= '0;
      vec_q    <= '0;
      off_q    <= '0;
      rdata_q  <= '0;
    end else begin
      prev_q <= in_s;
      pend_q <= pend_d;
      if (wr_eicr)   eicr_q   <= reg_wdata[0];
      if (wr_eimsk)  eimsk_q  <= reg_wdata[CH-1:0];
      if (wr_eismsk) eismsk_q <= reg_wdata[CH-1:0];
      if (reg_re)    rdata_q  <= rdata_d;
      if (present) begin
        ripl_q <= cand_ripl;
        vec_q  <= cand_idx;
        off_q  <= eic_offset(cand_idx);
      end else begin
        ripl_q <= '0;
      end
    end
  end

  assign reg_rdata     = rdata_q;
  assign EIC_Interrupt = ripl_q;
  assign EIC_Vector    = vec_q;
  assign EIC_Offset    = off_q;
  assign EIC_ShadowSet = 4'd0;

endmodule
